// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one SRAM-like bus access per load/store,
// stalls the pipeline until it completes and returns the extended load result.
// Optional `DMEM_TIMEOUT_EN adds a WAIT watchdog with a bus_err pulse.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req,
  input  logic [2:0]  lshb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        adel,
`ifdef DMEM_TIMEOUT_EN
  output logic        ades,
  output logic        bus_err
`else
  output logic        ades
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d, wr_q, wr_d, cancel_q, cancel_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]  strb_q, strb_d;

  logic        is_store, misalign, req_ok, start, comp, tmo;
  logic [1:0]  size_c;
  logic [3:0]  strb_c;
  logic [31:0] wdat_c, ext_c;

  assign is_store = lshb[2] & (lshb != 3'b100);

  always_comb begin
    size_c = 2'd2;
    case (lshb)
      3'b000, 3'b001, 3'b101: size_c = 2'd0;
      3'b010, 3'b011, 3'b110: size_c = 2'd1;
      default:                size_c = 2'd2;
    endcase
  end

  assign misalign = ((size_c == 2'd1) & addr[0]) | ((size_c == 2'd2) & (addr[1:0] != 2'b00));
  assign req_ok   = (state_q == S_IDLE) & mem_req & ~flush;
  assign start    = req_ok & ~misalign;
  assign adel     = req_ok & misalign & ~is_store;
  assign ades     = req_ok & misalign & is_store;

  // Store lane replication; loads carry wdata through but strobe nothing.
  always_comb begin
    strb_c = 4'b0000;
    wdat_c = wdata;
    case (lshb)
      3'b101: begin
        strb_c = 4'b0001 << addr[1:0];
        wdat_c = {4{wdata[7:0]}};
      end
      3'b110: begin
        strb_c = addr[1] ? 4'b1100 : 4'b0011;
        wdat_c = {2{wdata[15:0]}};
      end
      3'b111:  strb_c = 4'b1111;
      default: strb_c = 4'b0000;
    endcase
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = data_rdata[8*addr_q[1:0] +: 8];
    h = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      3'b000:  ext_c = {{24{b[7]}}, b};
      3'b001:  ext_c = {24'd0, b};
      3'b010:  ext_c = {{16{h[15]}}, h};
      3'b011:  ext_c = {16'd0, h};
      default: ext_c = data_rdata;
    endcase
  end

  assign comp = ((state_q == S_REQ) & data_addr_ok & data_data_ok) |
                ((state_q == S_WAIT) & data_data_ok);

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo     = (state_q == S_WAIT) & ~data_data_ok & (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign bus_err = tmo;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_REQ && data_addr_ok) cnt_d = '0;
    else if (state_q == S_WAIT)           cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wr_d     = wr_q;
    size_d   = size_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    strb_d   = strb_q;
    cancel_d = cancel_q;
    rdat_d   = rdat_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_REQ;
        req_d    = 1'b1;
        wr_d     = is_store;
        size_d   = size_c;
        op_d     = lshb;
        addr_d   = addr;
        wdat_d   = wdat_c;
        strb_d   = strb_c;
        cancel_d = 1'b0;
      end
      S_REQ: begin
        if (flush) cancel_d = 1'b1;
        if (data_addr_ok) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) cancel_d = 1'b1;
        if (tmo) begin
          state_d  = S_IDLE;
          cancel_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flushed access still drains the bus but retires silently.
    if (comp) begin
      cancel_d = 1'b0;
      if (cancel_q | flush) state_d = S_IDLE;
      else begin
        state_d = S_DONE;
        if (!wr_q) rdat_d = ext_c;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      op_q     <= 3'd0;
      addr_q   <= '0;
      wdat_q   <= '0;
      strb_q   <= '0;
      cancel_q <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      strb_q   <= strb_d;
      cancel_q <= cancel_d;
      rdat_q   <= rdat_d;
    end
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdat_q;
  assign data_wstrb = strb_q;
  assign rdata_out  = rdat_q;
  assign done       = (state_q == S_DONE);
  assign stall      = start | (state_q == S_REQ) | ((state_q == S_WAIT) & ~tmo);

endmodule
